// File: rtl/game_pkg.sv
// Shared definitions for the game controller sequencer: ctrl/who codes,
// FSM state encoding and result tally helpers.
package game_pkg;

    localparam logic [1:0] CTRL_INC1 = 2'b00;
    localparam logic [1:0] CTRL_INC2 = 2'b01;
    localparam logic [1:0] CTRL_DEC1 = 2'b10;
    localparam logic [1:0] CTRL_DEC2 = 2'b11;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_LOSE = 2'b01;
    localparam logic [1:0] WHO_WIN  = 2'b10;

    localparam int TALLY_W = 8;
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_PAUSE
    } state_t;

    // Tallies stick at their maximum instead of wrapping back to zero.
    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == TALLY_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/game_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and a synchronous flush.
// Read data is presented from the head entry without waiting for a pop.
module game_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/game_ctrl_sequencer.sv
// Session sequencer feeding queued ctrl codes to the game counter and tallying results.
// Define GAME_SEQ_AUTOPLAY_EN to replace PAUSE with LFSR-generated ctrl codes.
module game_ctrl_sequencer
    import game_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   seed_val,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_data,
    output logic               cmd_ready,
    output logic [1:0]         ctrl,
    output logic               init,
    output logic [WIDTH-1:0]   initial_val,
    input  logic               gameover,
    input  logic [1:0]         who,
    output logic               busy,
    output logic               match_done,
    output logic [TALLY_W-1:0] win_tally,
    output logic [TALLY_W-1:0] loss_tally
);

    state_t               state;
    state_t               next_state;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic [1:0]           fifo_rdata;
    logic                 start_ok;
    logic                 abort;
    logic [1:0]           ctrl_d;
    logic                 init_d;
    logic [WIDTH-1:0]     initial_val_d;
    logic [TALLY_W-1:0]   win_d;
    logic [TALLY_W-1:0]   loss_d;
    logic                 match_d;

    assign start_ok   = (state == ST_IDLE) && start && !stop;
    assign abort      = (state != ST_IDLE) && stop;
    assign fifo_flush = abort;
    assign fifo_pop   = (state == ST_RUN) && !fifo_empty && !stop;
    assign cmd_ready  = !fifo_full;
    assign busy       = (state != ST_IDLE);

    game_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef GAME_SEQ_AUTOPLAY_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, stepping only while in RUN.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_RUN) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_ok) next_state = ST_INIT;
            ST_INIT:  next_state = ST_RUN;
`ifdef GAME_SEQ_AUTOPLAY_EN
            ST_RUN:   next_state = ST_RUN;
`else
            ST_RUN:   if (fifo_empty) next_state = ST_PAUSE;
`endif
            ST_PAUSE: if (!fifo_empty) next_state = ST_RUN;
            default:  next_state = ST_IDLE;
        endcase
        if (abort) next_state = ST_IDLE;
    end

    // Next values of the registered outputs; init stays high until a code is issued.
    always_comb begin
        ctrl_d        = ctrl;
        init_d        = init;
        initial_val_d = initial_val;
        win_d         = win_tally;
        loss_d        = loss_tally;
        match_d       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    initial_val_d = seed_val;
                    win_d         = '0;
                    loss_d        = '0;
                    init_d        = 1'b1;
                end
            end
            ST_INIT:  init_d = 1'b1;
            ST_RUN: begin
                if (!fifo_empty) begin
                    ctrl_d = fifo_rdata;
                    init_d = 1'b0;
                end else begin
`ifdef GAME_SEQ_AUTOPLAY_EN
                    ctrl_d = lfsr[1:0];
                    init_d = 1'b0;
`else
                    init_d = 1'b1;
`endif
                end
            end
            ST_PAUSE: init_d = 1'b1;
            default:  init_d = 1'b1;
        endcase
        if ((state != ST_IDLE) && gameover) begin
            if (who == WHO_WIN) begin
                win_d   = sat_inc(win_tally);
                match_d = 1'b1;
            end else if (who == WHO_LOSE) begin
                loss_d  = sat_inc(loss_tally);
                match_d = 1'b1;
            end
        end
        if (abort) begin
            ctrl_d = CTRL_INC1;
            init_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl        <= CTRL_INC1;
            init        <= 1'b1;
            initial_val <= '0;
            win_tally   <= '0;
            loss_tally  <= '0;
            match_done  <= 1'b0;
        end else begin
            ctrl        <= ctrl_d;
            init        <= init_d;
            initial_val <= initial_val_d;
            win_tally   <= win_d;
            loss_tally  <= loss_d;
            match_done  <= match_d;
        end
    end

endmodule

// File: tb/tb_game_ctrl_sequencer.sv
// Directed self-checking bench for game_ctrl_sequencer; the autoplay section
// is selected when GAME_SEQ_AUTOPLAY_EN is defined.
module tb_game_ctrl_sequencer;
    import game_pkg::*;

    localparam int WIDTH = 3;
    localparam int DEPTH = 8;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   seed_val;
    logic               cmd_valid;
    logic [1:0]         cmd_data;
    logic               cmd_ready;
    logic [1:0]         ctrl;
    logic               init;
    logic [WIDTH-1:0]   initial_val;
    logic               gameover;
    logic [1:0]         who;
    logic               busy;
    logic               match_done;
    logic [TALLY_W-1:0] win_tally;
    logic [TALLY_W-1:0] loss_tally;

    int n_compared   = 0;
    int n_mismatched = 0;
    int pulses       = 0;
    logic [1:0] pat [8];

    game_ctrl_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .seed_val    (seed_val),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .ctrl        (ctrl),
        .init        (init),
        .initial_val (initial_val),
        .gameover    (gameover),
        .who         (who),
        .busy        (busy),
        .match_done  (match_done),
        .win_tally   (win_tally),
        .loss_tally  (loss_tally)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] code);
        cmd_valid = 1'b1;
        cmd_data  = code;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ctrl"}, 32'(ctrl), 32'(CTRL_INC1));
        check_output({tag, "_init"}, 32'(init), 32'd1);
        check_output({tag, "_initial_val"}, 32'(initial_val), 32'd0);
        check_output({tag, "_win"}, 32'(win_tally), 32'd0);
        check_output({tag, "_loss"}, 32'(loss_tally), 32'd0);
        check_output({tag, "_match_done"}, 32'(match_done), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        seed_val  = '0;
        cmd_valid = 1'b0;
        cmd_data  = CTRL_INC1;
        gameover  = 1'b0;
        who       = WHO_NONE;
        pat = '{CTRL_DEC2, CTRL_DEC1, CTRL_INC2, CTRL_INC1,
                CTRL_INC1, CTRL_INC2, CTRL_DEC1, CTRL_DEC2};

        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;

        // Pre-load three commands, then run a session seeded with 3.
        push_cmd(CTRL_INC1);
        push_cmd(CTRL_INC2);
        push_cmd(CTRL_DEC1);
        check_output("preload_ready", 32'(cmd_ready), 32'd1);
        seed_val = 3'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        check_output("init_busy", 32'(busy), 32'd1);
        check_output("init_init", 32'(init), 32'd1);
        check_output("init_seed", 32'(initial_val), 32'd3);
        step();
        step();
        check_output("run_ctrl0", 32'(ctrl), 32'(CTRL_INC1));
        check_output("run_init0", 32'(init), 32'd0);
        step();
        check_output("run_ctrl1", 32'(ctrl), 32'(CTRL_INC2));
        check_output("run_init1", 32'(init), 32'd0);
        step();
        check_output("run_ctrl2", 32'(ctrl), 32'(CTRL_DEC1));
        check_output("run_init2", 32'(init), 32'd0);
        step();
`ifndef GAME_SEQ_AUTOPLAY_EN
        check_output("pause_init", 32'(init), 32'd1);
        check_output("pause_ctrl", 32'(ctrl), 32'(CTRL_DEC1));
        step();
        check_output("pause_hold_init", 32'(init), 32'd1);
        check_output("pause_busy", 32'(busy), 32'd1);
`endif

        // Three wins and one loss, each a single-cycle pulse.
        for (int i = 0; i < 4; i++) begin
            gameover = 1'b1;
            who      = (i == 3) ? WHO_LOSE : WHO_WIN;
            step();
            gameover = 1'b0;
            if (match_done) pulses++;
            step();
            if (match_done) pulses++;
        end
        check_output("tally_win3", 32'(win_tally), 32'd3);
        check_output("tally_loss1", 32'(loss_tally), 32'd1);
        check_output("tally_pulses", 32'(pulses), 32'd4);
        gameover = 1'b1;
        who      = 2'b11;
        step();
        check_output("who11_match", 32'(match_done), 32'd0);
        who = WHO_NONE;
        step();
        gameover = 1'b0;
        check_output("who00_win", 32'(win_tally), 32'd3);
        check_output("who00_loss", 32'(loss_tally), 32'd1);

        // 260 further wins must saturate at 255.
        gameover = 1'b1;
        who      = WHO_WIN;
        repeat (260) step();
        gameover = 1'b0;
        check_output("sat_win", 32'(win_tally), 32'd255);
        check_output("sat_loss", 32'(loss_tally), 32'd1);
        step();
        check_output("sat_match_clear", 32'(match_done), 32'd0);

        stop = 1'b1;
        step();
        stop = 1'b0;
        check_output("stop_busy", 32'(busy), 32'd0);
        check_output("stop_init", 32'(init), 32'd1);
        check_output("stop_ctrl", 32'(ctrl), 32'(CTRL_INC1));
        check_output("stop_win_kept", 32'(win_tally), 32'd255);

        gameover = 1'b1;
        who      = WHO_WIN;
        step();
        gameover = 1'b0;
        check_output("idle_gameover_match", 32'(match_done), 32'd0);
        check_output("idle_gameover_win", 32'(win_tally), 32'd255);

        // Start and stop together in IDLE: stop wins, nothing is captured.
        seed_val = 3'd5;
        start    = 1'b1;
        stop     = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_output("startstop_busy", 32'(busy), 32'd0);
        check_output("startstop_seed", 32'(initial_val), 32'd3);
        check_output("startstop_win", 32'(win_tally), 32'd255);
        step();
        check_output("startstop_busy2", 32'(busy), 32'd0);

        // Fill the FIFO in IDLE; the ninth push must be dropped.
        for (int i = 0; i < 7; i++) push_cmd(pat[i]);
        check_output("fill7_ready", 32'(cmd_ready), 32'd1);
        push_cmd(pat[7]);
        check_output("fill8_ready", 32'(cmd_ready), 32'd0);
        push_cmd(CTRL_INC2);
        check_output("fill9_ready", 32'(cmd_ready), 32'd0);
        seed_val = 3'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        check_output("drain_seed", 32'(initial_val), 32'd5);
        check_output("drain_win_clear", 32'(win_tally), 32'd0);
        check_output("drain_loss_clear", 32'(loss_tally), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_output($sformatf("drain_ctrl%0d", i), 32'(ctrl), 32'(pat[i]));
            check_output($sformatf("drain_init%0d", i), 32'(init), 32'd0);
        end
`ifndef GAME_SEQ_AUTOPLAY_EN
        step();
        check_output("drain_end_init", 32'(init), 32'd1);
        check_output("drain_end_ctrl", 32'(ctrl), 32'(CTRL_DEC2));
`endif

        // Stop during RUN with four commands still queued.
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 8; i++) push_cmd(pat[i]);
        seed_val = 3'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        gameover = 1'b1;
        who      = WHO_WIN;
        step();
        gameover = 1'b0;
        check_output("q4_ctrl0", 32'(ctrl), 32'(pat[0]));
        step();
        step();
        step();
        check_output("q4_ctrl3", 32'(ctrl), 32'(pat[3]));
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_output("q4_stop_busy", 32'(busy), 32'd0);
        check_output("q4_stop_init", 32'(init), 32'd1);
        check_output("q4_stop_ctrl", 32'(ctrl), 32'(CTRL_INC1));
        check_output("q4_stop_ready", 32'(cmd_ready), 32'd1);
        check_output("q4_stop_win", 32'(win_tally), 32'd1);
        check_output("q4_stop_loss", 32'(loss_tally), 32'd0);
`ifndef GAME_SEQ_AUTOPLAY_EN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_output("flushed_ctrl", 32'(ctrl), 32'(CTRL_INC1));
        check_output("flushed_init", 32'(init), 32'd1);
`endif

        // Reset mid-session while a push and a result arrive.
        cmd_valid = 1'b1;
        cmd_data  = CTRL_DEC1;
        gameover  = 1'b1;
        who       = WHO_WIN;
        reset     = 1'b1;
        step();
        check_reset_values("midreset");
        cmd_valid = 1'b0;
        gameover  = 1'b0;
        reset     = 1'b0;
        step();
        check_reset_values("postreset");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
`ifndef GAME_SEQ_AUTOPLAY_EN
        check_output("postreset_ctrl", 32'(ctrl), 32'(CTRL_INC1));
        check_output("postreset_init", 32'(init), 32'd1);
`else
        // LFSR from 8'hA5: A5, 4A, 95, 2A -> low bits 01, 10, 01, 10.
        check_output("auto_ctrl0", 32'(ctrl), 32'h1);
        check_output("auto_init0", 32'(init), 32'd0);
        step();
        check_output("auto_ctrl1", 32'(ctrl), 32'h2);
        step();
        check_output("auto_ctrl2", 32'(ctrl), 32'h1);
        step();
        check_output("auto_ctrl3", 32'(ctrl), 32'h2);
        check_output("auto_init3", 32'(init), 32'd0);
        check_output("auto_busy", 32'(busy), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
